// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types and helpers for the cache-bus arbiter and other round-robin arbiters.
package cache_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WRESP = 3'd3,
        RDATA = 3'd4
    } arb_state_e;

    localparam int unsigned ARB_MAX_PORTS = 32;

    // One-hot winner: first set bit of valid[n-1:0] scanning upward from ptr, wrapping at n.
    function automatic logic [ARB_MAX_PORTS-1:0] rr_pick(
        input logic [ARB_MAX_PORTS-1:0] valid,
        input int unsigned              ptr,
        input int unsigned              n
    );
        logic [ARB_MAX_PORTS-1:0] onehot;
        logic                     found;
        int unsigned              idx;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < ARB_MAX_PORTS; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && valid[idx[4:0]]) begin
                    onehot[idx[4:0]] = 1'b1;
                    found            = 1'b1;
                end
            end
        end
        return onehot;
    endfunction

endpackage

// File: rtl/cache_bus_arbiter_picker.sv
// Combinational round-robin picker: request vector + start pointer -> winning index.
module rr_priority_picker
    import cache_bus_arbiter_pkg::*;
#(
    parameter int PORT_NUM = 2,
    parameter int IDX_W    = $clog2(PORT_NUM)
) (
    input  logic [PORT_NUM-1:0] valid_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [IDX_W-1:0]    grant_o,
    output logic                any_valid_o
);

    logic [ARB_MAX_PORTS-1:0] valid_ext;
    logic [ARB_MAX_PORTS-1:0] onehot;

    always_comb begin
        valid_ext                 = '0;
        valid_ext[PORT_NUM-1:0]   = valid_i;
        onehot                    = rr_pick(valid_ext, int'(ptr_i), PORT_NUM);
        grant_o                   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (onehot[i]) grant_o = IDX_W'(i);
        end
        any_valid_o = |onehot;
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Whole-transaction arbiter sharing one downstream cache-bus port among PORT_NUM masters.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int PORT_NUM = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORT_NUM-1:0]          up_req_valid_i,
    input  logic [PORT_NUM-1:0]          up_req_write_i,
    input  logic [PORT_NUM*ADDR_W-1:0]   up_req_addr_i,
    input  logic [PORT_NUM*LEN_W-1:0]    up_req_len_i,
    output logic [PORT_NUM-1:0]          up_req_ready_o,
    input  logic [PORT_NUM-1:0]          up_wvalid_i,
    input  logic [PORT_NUM*DATA_W-1:0]   up_wdata_i,
    input  logic [PORT_NUM*DATA_W/8-1:0] up_wstrb_i,
    input  logic [PORT_NUM-1:0]          up_wlast_i,
    output logic [PORT_NUM-1:0]          up_wready_o,
    output logic [PORT_NUM-1:0]          up_rvalid_o,
    output logic [DATA_W-1:0]            up_rdata_o,
    output logic                         up_rlast_o,
    output logic [PORT_NUM-1:0]          up_wdone_o,
    output logic                         dn_req_valid_o,
    output logic                         dn_req_write_o,
    output logic [ADDR_W-1:0]            dn_req_addr_o,
    output logic [LEN_W-1:0]             dn_req_len_o,
    input  logic                         dn_req_ready_i,
    output logic                         dn_wvalid_o,
    output logic [DATA_W-1:0]            dn_wdata_o,
    output logic [DATA_W/8-1:0]          dn_wstrb_o,
    output logic                         dn_wlast_o,
    input  logic                         dn_wready_i,
    input  logic                         dn_rvalid_i,
    input  logic [DATA_W-1:0]            dn_rdata_i,
    input  logic                         dn_rlast_i,
    input  logic                         dn_wdone_i
);

    localparam int IDX_W  = $clog2(PORT_NUM);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] scan_ptr, pick_idx;
    logic             pick_any;

`ifdef ARB_FIXED_PRIO_EN
    assign scan_ptr = '0;
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             txn_done;

    assign scan_ptr = ptr_q;
    assign txn_done = (state_q == WRESP && dn_wdone_i) ||
                      (state_q == RDATA && dn_rvalid_i && dn_rlast_i);

    always_comb begin
        ptr_d = ptr_q;
        if (txn_done) ptr_d = (grant_q == IDX_W'(PORT_NUM - 1)) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    rr_priority_picker #(
        .PORT_NUM (PORT_NUM),
        .IDX_W    (IDX_W)
    ) u_picker (
        .valid_i     (up_req_valid_i),
        .ptr_i       (scan_ptr),
        .grant_o     (pick_idx),
        .any_valid_o (pick_any)
    );

    // Granted port's view of the upstream bus.
    logic sel_req_valid, sel_write, sel_wvalid, sel_wlast;
    always_comb begin
        sel_req_valid = up_req_valid_i[grant_q];
        sel_write     = up_req_write_i[grant_q];
        sel_wvalid    = up_wvalid_i[grant_q];
        sel_wlast     = up_wlast_i[grant_q];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE:    if (pick_any) begin
                         grant_d = pick_idx;
                         state_d = ADDR;
                     end
            ADDR:    if (sel_req_valid && dn_req_ready_i) state_d = sel_write ? WDATA : RDATA;
            WDATA:   if (sel_wvalid && dn_wready_i && sel_wlast) state_d = WRESP;
            WRESP:   if (dn_wdone_i) state_d = IDLE;
            RDATA:   if (dn_rvalid_i && dn_rlast_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Data fields always follow grant_q; only valids/readys are gated by state.
    always_comb begin
        dn_req_valid_o = (state_q == ADDR) && sel_req_valid;
        dn_req_write_o = sel_write;
        dn_req_addr_o  = up_req_addr_i[grant_q*ADDR_W +: ADDR_W];
        dn_req_len_o   = up_req_len_i[grant_q*LEN_W +: LEN_W];
        dn_wvalid_o    = (state_q == WDATA) && sel_wvalid;
        dn_wdata_o     = up_wdata_i[grant_q*DATA_W +: DATA_W];
        dn_wstrb_o     = up_wstrb_i[grant_q*STRB_W +: STRB_W];
        dn_wlast_o     = sel_wlast;
        up_rdata_o     = dn_rdata_i;
        up_rlast_o     = dn_rlast_i;
        up_req_ready_o = '0;
        up_wready_o    = '0;
        up_rvalid_o    = '0;
        up_wdone_o     = '0;
        case (state_q)
            ADDR:    up_req_ready_o[grant_q] = dn_req_ready_i;
            WDATA:   up_wready_o[grant_q]    = dn_wready_i;
            WRESP:   up_wdone_o[grant_q]     = dn_wdone_i;
            RDATA:   up_rvalid_o[grant_q]    = dn_rvalid_i;
            default: ;
        endcase
    end

endmodule
